// File: rtl/bidir_line_ctrl.sv
// Half-duplex controller for one bidirectional pad behind a BB tristate primitive.
// Arbitrates TX/RX requests, serialises TX words LSB-first and samples RX words.
module bidir_line_ctrl #(
  parameter int WIDTH      = 8,
  parameter int BIT_CLOCKS = 4,
  parameter int TURNAROUND = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  output logic             rx_ack,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  input  logic             pad_i,
  output logic             pad_o,
  output logic             pad_t
);

  typedef enum logic [1:0] {IDLE, TX, TURN, RX} state_t;

  localparam int PW = $clog2(BIT_CLOCKS);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(BIT_CLOCKS - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(BIT_CLOCKS / 2);
  localparam logic [BW-1:0] BIT_LAST     = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TURN_LAST    = TW'(TURNAROUND - 1);

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [BW-1:0]    r_bitCnt;
  logic [TW-1:0]    r_turnCnt;
  logic [WIDTH-1:0] r_txShift;
  logic [WIDTH-1:0] r_rxShift;
  logic [WIDTH-1:0] r_rxData;
  logic             r_rxValid;
  logic             r_padT;
  logic             r_padO;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_lastTx;

  state_t           w_stateNext;
  logic [PW-1:0]    w_phaseNext;
  logic [BW-1:0]    w_bitNext;
  logic [TW-1:0]    w_turnNext;
  logic [WIDTH-1:0] w_txShiftNext;
  logic [WIDTH-1:0] w_rxShiftNext;
  logic [WIDTH-1:0] w_rxDataNext;
  logic [WIDTH-1:0] w_rxShifted;
  logic             w_rxValidNext;
  logic             w_lastTxNext;
  logic             w_txGrant;
  logic             w_rxGrant;
  logic             w_bitEnd;
  logic             w_wordDone;

  assign w_rxShifted = (r_rxShift >> 1) | (WIDTH'(r_sync2) << (WIDTH - 1));
  assign w_bitEnd    = (r_phase == PHASE_LAST);
  assign w_wordDone  = w_bitEnd && (r_bitCnt == BIT_LAST);

  always_comb begin
    w_stateNext   = r_state;
    w_phaseNext   = r_phase;
    w_bitNext     = r_bitCnt;
    w_turnNext    = r_turnCnt;
    w_txShiftNext = r_txShift;
    w_rxShiftNext = r_rxShift;
    w_rxDataNext  = r_rxData;
    w_rxValidNext = 1'b0;
    w_lastTxNext  = r_lastTx;
    w_txGrant     = 1'b0;
    w_rxGrant     = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the side that was not served last wins.
        w_txGrant = !reset && tx_valid && (!rx_req || !r_lastTx);
        w_rxGrant = !reset && rx_req && (!tx_valid || r_lastTx);
        if (w_txGrant) begin
          w_stateNext   = TX;
          w_txShiftNext = tx_data;
          w_phaseNext   = '0;
          w_bitNext     = '0;
          w_lastTxNext  = 1'b1;
        end else if (w_rxGrant) begin
          w_stateNext  = RX;
          w_phaseNext  = '0;
          w_bitNext    = '0;
          w_lastTxNext = 1'b0;
        end
      end
      TX: begin
        w_phaseNext = w_bitEnd ? '0 : r_phase + PW'(1);
        if (w_bitEnd) begin
          w_bitNext     = r_bitCnt + BW'(1);
          w_txShiftNext = r_txShift >> 1;
        end
        if (w_wordDone) begin
          w_stateNext = TURN;
          w_bitNext   = '0;
          w_turnNext  = '0;
        end
      end
      TURN: begin
        w_turnNext = r_turnCnt + TW'(1);
        if (r_turnCnt == TURN_LAST) begin
          w_stateNext = IDLE;
          w_turnNext  = '0;
        end
      end
      RX: begin
        if (r_phase == PHASE_SAMPLE) w_rxShiftNext = w_rxShifted;
        w_phaseNext = w_bitEnd ? '0 : r_phase + PW'(1);
        if (w_bitEnd) w_bitNext = r_bitCnt + BW'(1);
        if (w_wordDone) begin
          w_stateNext   = IDLE;
          w_bitNext     = '0;
          w_rxDataNext  = w_rxShiftNext;
          w_rxValidNext = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Pad controls are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_bitCnt  <= '0;
      r_turnCnt <= '0;
      r_txShift <= '0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_padT    <= 1'b1;
      r_padO    <= 1'b1;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_lastTx  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_phase   <= w_phaseNext;
      r_bitCnt  <= w_bitNext;
      r_turnCnt <= w_turnNext;
      r_txShift <= w_txShiftNext;
      r_rxShift <= w_rxShiftNext;
      r_rxData  <= w_rxDataNext;
      r_rxValid <= w_rxValidNext;
      r_padT    <= (w_stateNext != TX);
      r_padO    <= (w_stateNext == TX) ? w_txShiftNext[0] : 1'b1;
      r_sync1   <= pad_i;
      r_sync2   <= r_sync1;
      r_lastTx  <= w_lastTxNext;
    end
  end

  assign tx_ready = w_txGrant;
  assign rx_ack   = w_rxGrant;
  assign rx_valid = r_rxValid;
  assign rx_data  = r_rxData;
  assign busy     = (r_state != IDLE);
  assign pad_o    = r_padO;
  assign pad_t    = r_padT;

endmodule

// File: tb/tb_bidir_line_ctrl.sv
// Self-checking bench for bidir_line_ctrl: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_bidir_line_ctrl;

  localparam int W  = 8;
  localparam int B  = 4;
  localparam int T  = 2;
  localparam int WB = W * B;

  logic         clock;
  logic         reset;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;
  logic         rx_req;
  logic         rx_ack;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         pad_i;
  logic         pad_o;
  logic         pad_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bidir_line_ctrl #(.WIDTH(W), .BIT_CLOCKS(B), .TURNAROUND(T)) dut (
    .clock(clock), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance to the next cycle, drive inputs for it, and return at its falling edge.
  task automatic applyStimulus(input logic rst, input logic txv, input logic [W-1:0] txd,
                               input logic rxr, input logic pi);
    @(posedge clock);
    #1;
    reset = rst; tx_valid = txv; tx_data = txd; rx_req = rxr; pad_i = pi;
    @(negedge clock);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Transaction model: mode 0 idle, 1 transmit, 2 receive, timed from the accept cycle.
  bit           hist [0:8191];
  int           mMode   = 0;
  int           mStart  = 0;
  bit           mLastTx = 0;
  bit           mValid  = 0;
  logic [W-1:0] mWord   = '0;
  logic [W-1:0] mRxData = '0;

  always @(negedge clock) begin
    int d;
    logic expT, expO, expBusy, expRv, expTr, expRa;
    hist[cyc] = pad_i;
    if (reset) begin
      checkOutput("grants_in_reset", {tx_ready, rx_ack}, 2'b00);
      mMode = 0; mLastTx = 0; mRxData = '0; mValid = 1;
    end else if (mValid) begin
      d = cyc - mStart;
      expRv = 1'b0;
      if (mMode == 2 && d == WB + 1) begin
        for (int k = 0; k < W; k++) mRxData[k] = hist[mStart + 1 + k * B + B / 2 - 2];
        expRv = 1'b1;
        mMode = 0;
      end
      if (mMode == 1 && d > WB + T) mMode = 0;
      expT = !(mMode == 1 && d >= 1 && d <= WB);
      expO = expT ? 1'b1 : mWord[(d - 1) / B];
      expBusy = (mMode != 0);
      expTr = 1'b0; expRa = 1'b0;
      if (mMode == 0) begin
        expTr = tx_valid && (!rx_req || !mLastTx);
        expRa = rx_req && (!tx_valid || mLastTx);
        if (expTr) begin
          mMode = 1; mStart = cyc; mWord = tx_data; mLastTx = 1;
        end else if (expRa) begin
          mMode = 2; mStart = cyc; mLastTx = 0;
        end
      end
      checkOutput("model_pad_t", pad_t, expT);
      checkOutput("model_pad_o", pad_o, expO);
      checkOutput("model_busy", busy, expBusy);
      checkOutput("model_tx_ready", tx_ready, expTr);
      checkOutput("model_rx_ack", rx_ack, expRa);
      checkOutput("model_rx_valid", rx_valid, expRv);
      checkOutput("model_rx_data", rx_data, mRxData);
    end
  end

  task automatic doRx(input logic [W-1:0] word, input logic [W-1:0] required, input string tag);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput({tag, "_accept"}, rx_ack, 1'b1);
    for (int i = 1; i <= WB + 1; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, (i <= WB) ? word[(i - 1) / B] : 1'b1);
      checkOutput({tag, "_pad_t"}, pad_t, 1'b1);
      checkOutput({tag, "_rx_valid"}, rx_valid, (i == WB + 1));
      if (i == WB + 1) checkOutput({tag, "_rx_data"}, rx_data, required);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit pat [8];
    int gKind [$];
    int gCyc [$];
    int cnt;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_req = 1'b0; pad_i = 1'b1;

    // Reset state.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("reset_pad_t", pad_t, 1'b1);
    checkOutput("reset_pad_o", pad_o, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_tx_ready", tx_ready, 1'b0);
    checkOutput("reset_rx_ack", rx_ack, 1'b0);
    idleCycles(2);

    // Single TX of A5; tx_data changes right after acceptance.
    pat = '{1, 0, 1, 0, 0, 1, 0, 1};
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    checkOutput("tx_accept", tx_ready, 1'b1);
    for (int i = 1; i <= 35; i++) begin
      applyStimulus(1'b0, (i >= 33), 8'h3E, 1'b0, 1'b1);
      if (i <= 32) begin
        checkOutput("tx_pad_t", pad_t, 1'b0);
        checkOutput("tx_pad_o", pad_o, pat[(i - 1) / 4]);
      end else if (i <= 34) begin
        checkOutput("turn_pad_t", pad_t, 1'b1);
        checkOutput("turn_tx_ready", tx_ready, 1'b0);
      end else begin
        checkOutput("tx_reaccept", tx_ready, 1'b1);
      end
    end
    idleCycles(40);

    // Single RX of 3C.
    doRx(8'h3C, 8'h3C, "rx1");
    idleCycles(3);

    // Tie alternation from reset release.
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 160 && gKind.size() < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
      if (tx_ready) begin gKind.push_back(1); gCyc.push_back(cyc); end
      if (rx_ack)   begin gKind.push_back(0); gCyc.push_back(cyc); end
    end
    checkOutput("tie_grant_count", gKind.size(), 4);
    if (gKind.size() == 4) begin
      checkOutput("tie_order", {gKind[0][0], gKind[1][0], gKind[2][0], gKind[3][0]}, 4'b1010);
      checkOutput("tie_gap_tx_rx", gCyc[1] - gCyc[0], 35);
      checkOutput("tie_gap_rx_tx", gCyc[2] - gCyc[1], 33);
      checkOutput("tie_gap_tx_rx2", gCyc[3] - gCyc[2], 35);
    end
    idleCycles(40);

    // Reset in the middle of a transmit, then a tie goes to TX.
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
    checkOutput("midtx_accept", tx_ready, 1'b1);
    idleCycles(9);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b1, 1'b1);
    checkOutput("midtx_pad_t", pad_t, 1'b1);
    checkOutput("midtx_busy", busy, 1'b0);
    checkOutput("midtx_rx_valid", rx_valid, 1'b0);
    checkOutput("midtx_tie_tx", tx_ready, 1'b1);
    checkOutput("midtx_tie_rx", rx_ack, 1'b0);
    idleCycles(40);

    // Reset in the middle of a receive after a prior word.
    doRx(8'h5A, 8'h5A, "rx2");
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("midrx_accept", rx_ack, 1'b1);
    for (int i = 1; i <= 19; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, i[0]);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("midrx_rx_data", rx_data, 8'h00);
    checkOutput("midrx_busy", busy, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (rx_valid) cnt++;
    end
    checkOutput("midrx_no_valid", cnt, 0);
    doRx(8'h96, 8'h96, "rx3");
    idleCycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
